// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: one Kogge-Stone chunk of `width` bits is reused
// for `words` cycles, rippling the carry through a register between chunks.
module multiword_add_seq #(
   parameter int width = 22,
   parameter int words = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [width*words-1:0]   A,
   input  logic [width*words-1:0]   B,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [width*words-1:0]   S,
   output logic                     cout,
   output logic                     busy
);

   localparam int TOTAL  = width * words;
   localparam int IDX_W  = $clog2(words + 1);
   localparam int LEVELS = (width > 1) ? $clog2(width) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TOTAL-1:0]   a_q, a_d;
   logic [TOTAL-1:0]   b_q, b_d;
   logic [TOTAL-1:0]   s_q, s_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [width-1:0]   ks_a, ks_b, ks_sum;
   logic [width-1:0]   ks_prop, ks_g, ks_p, ks_g_n, ks_p_n;
   logic               ks_cin, ks_cout;

   assign ks_a   = a_q[width-1:0];
   assign ks_b   = b_q[width-1:0];
   assign ks_cin = carry_q;

   // Carry-in is folded into bit 0's generate so the prefix tree yields c[i+1] directly.
   always_comb begin
      ks_prop = ks_a ^ ks_b;
      ks_g    = ks_a & ks_b;
      ks_p    = ks_prop;
      ks_g_n  = '0;
      ks_p_n  = '0;
      ks_g[0] = ks_g[0] | (ks_p[0] & ks_cin);
      for (int l = 0; l < LEVELS; l++) begin
         ks_g_n = ks_g;
         ks_p_n = ks_p;
         for (int i = 0; i < width; i++) begin
            if (i >= (1 << l)) begin
               ks_g_n[i] = ks_g[i] | (ks_p[i] & ks_g[i - (1 << l)]);
               ks_p_n[i] = ks_p[i] & ks_p[i - (1 << l)];
            end
         end
         ks_g = ks_g_n;
         ks_p = ks_p_n;
      end
      ks_sum    = ks_prop;
      ks_sum[0] = ks_prop[0] ^ ks_cin;
      for (int i = 1; i < width; i++) begin
         ks_sum[i] = ks_prop[i] ^ ks_g[i-1];
      end
      ks_cout = ks_g[width-1];
   end

   // Operands shift down one chunk per BUSY cycle and sum chunks shift in from the top,
   // so after `words` steps chunk k of the result sits at chunk k of S. One extra BUSY
   // cycle (idx == words) commits the final carry to cout before entering DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d     = A;
               b_d     = B;
               carry_d = cin;
               idx_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (idx_q < IDX_W'(words)) begin
               s_d     = {ks_sum, s_q[TOTAL-1:width]};
               a_d     = a_q >> width;
               b_d     = b_q >> width;
               carry_d = ks_cout;
               idx_d   = idx_q + IDX_W'(1);
            end else begin
               cout_d  = carry_q;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d == BUSY);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         a_q         <= a_d;
         b_q         <= b_d;
         s_q         <= s_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign S         = s_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: scoreboard of golden sums pushed at
// accept time and popped when the DUT presents a result.
module tb_multiword_add_seq;

   localparam int WIDTH = 22;
   localparam int WORDS = 3;
   localparam int TOT   = WIDTH * WORDS;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [TOT-1:0] A;
   logic [TOT-1:0] B;
   logic           cin;
   logic           out_valid;
   logic           out_ready;
   logic [TOT-1:0] S;
   logic           cout;
   logic           busy;

   int checks = 0;
   int errors = 0;
   logic [TOT:0] exp_q[$];

   multiword_add_seq #(.width(WIDTH), .words(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Drive one operand set; returns with time at accept edge + 1 and in_valid low.
   task automatic send_op(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                          input logic c, output bit ok);
      int n;
      n = 0;
      A = a;
      B = b;
      cin = c;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      ok = (in_ready === 1'b1);
      if (ok) begin
         @(posedge clk);
         exp_q.push_back({1'b0, a} + {1'b0, b} + {{TOT{1'b0}}, c});
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int edges);
      edges = 0;
      while (edges < 64) begin
         @(posedge clk); #1;
         edges++;
         if (out_valid === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      int edges;
      logic [TOT:0] expv;
      rst = 1'b1;
      in_valid = 1'b1;
      A = '1;
      B = '1;
      cin = 1'b1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b required 100", {in_ready, out_valid, busy});
      end
      checks++;
      if ({cout, S} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_sum: got %h required 0", {cout, S});
      end
      A = 66'd10;
      B = 66'd20;
      cin = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      exp_q.push_back(67'd30);
      #1;
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL first_accept: busy got %b required 1", busy);
      end
      wait_out(edges);
      checks++;
      if (edges !== WORDS + 1) begin
         errors++;
         $display("[TB] FAIL first_latency: got %0d required %0d", edges, WORDS + 1);
      end
      expv = exp_q.pop_front();
      checks++;
      if ({cout, S} !== expv) begin
         errors++;
         $display("[TB] FAIL first_sum: got %h required %h", {cout, S}, expv);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_basic();
      bit ok;
      int edges;
      logic [TOT:0] expv;
      out_ready = 1'b1;
      send_op(66'd1, 66'd2, 1'b0, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_accept: in_ready got %b required 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_busy: out_valid/busy got %b%b required 01", out_valid, busy);
      end
      wait_out(edges);
      checks++;
      if (edges !== 4) begin
         errors++;
         $display("[TB] FAIL basic_latency: got %0d required 4", edges);
      end
      expv = exp_q.pop_front();
      checks++;
      if ({cout, S} !== expv || S !== 66'd3) begin
         errors++;
         $display("[TB] FAIL basic_sum: got %h required %h", {cout, S}, expv);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_return: out_valid/in_ready got %b%b required 01", out_valid, in_ready);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_carry(input logic [TOT-1:0] a, input logic [TOT-1:0] b,
                             input logic c, input logic [TOT:0] required, input string name);
      bit ok;
      int edges;
      logic [TOT:0] expv;
      out_ready = 1'b1;
      send_op(a, b, c, ok);
      wait_out(edges);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_valid: got %b required 1", name, out_valid);
      end
      expv = exp_q.pop_front();
      checks++;
      if ({cout, S} !== expv || {cout, S} !== required) begin
         errors++;
         $display("[TB] FAIL %s_sum: got %h required %h", name, {cout, S}, required);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok;
      int edges;
      int bad;
      int extra;
      logic [TOT-1:0] s0;
      logic c0;
      logic [TOT:0] expv;
      out_ready = 1'b0;
      send_op(66'h2_1234_5678_9ABC_DEF0, 66'h1_FFFF_0000_FFFF_0000, 1'b1, ok);
      wait_out(edges);
      s0 = S;
      c0 = cout;
      bad = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (S !== s0 || cout !== c0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("[TB] FAIL bp_stable: unstable cycles got %0d required 0", bad);
      end
      expv = exp_q.pop_front();
      checks++;
      if ({cout, S} !== expv) begin
         errors++;
         $display("[TB] FAIL bp_sum: got %h required %h", {cout, S}, expv);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      extra = 0;
      repeat (5) begin
         if (out_valid !== 1'b0) extra++;
         @(posedge clk); #1;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("[TB] FAIL bp_single_transfer: valid cycles after transfer got %0d required 0", extra);
      end
   endtask

   task automatic test_ignore_inputs();
      bit ok;
      int edges;
      logic [TOT:0] expv;
      out_ready = 1'b0;
      send_op(66'd100, 66'd200, 1'b1, ok);
      A = '1;
      B = 66'h1_5555_5555_5555_5555;
      cin = 1'b0;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ignore_flags: in_ready/busy got %b%b required 01", in_ready, busy);
      end
      wait_out(edges);
      in_valid = 1'b0;
      expv = exp_q.pop_front();
      checks++;
      if ({cout, S} !== expv || S !== 66'd301) begin
         errors++;
         $display("[TB] FAIL ignore_sum: got %h required %h", {cout, S}, expv);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midop();
      bit ok;
      int edges;
      int stale;
      logic [TOT:0] expv;
      out_ready = 1'b1;
      send_op(66'h3_0000_1111_2222_3333, 66'h0_4444_5555_6666_7777, 1'b1, ok);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, cout} !== 4'b1000 || S !== '0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: flags got %b S %h required 1000 S 0",
                  {in_ready, out_valid, busy, cout}, S);
      end
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
      stale = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale !== 0) begin
         errors++;
         $display("[TB] FAIL midreset_stale: valid cycles got %0d required 0", stale);
      end
      send_op(66'd5, 66'd7, 1'b1, ok);
      wait_out(edges);
      expv = exp_q.pop_front();
      checks++;
      if ({cout, S} !== expv || S !== 66'd13) begin
         errors++;
         $display("[TB] FAIL midreset_next: got %h required %h", {cout, S}, expv);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      bit ok;
      int edges;
      int pass;
      logic [95:0] ra, rb;
      logic [TOT:0] expv;
      pass = 0;
      for (int n = 0; n < 500; n++) begin
         ra = {$urandom(), $urandom(), $urandom()};
         rb = {$urandom(), $urandom(), $urandom()};
         if (n % 50 == 7) ra = '1;
         out_ready = ($urandom_range(0, 1) == 1);
         send_op(ra[TOT-1:0], rb[TOT-1:0], 1'($urandom_range(0, 1)), ok);
         wait_out(edges);
         if (out_ready !== 1'b1) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk); #1;
            end
         end
         expv = exp_q.pop_front();
         checks++;
         if (out_valid !== 1'b1 || {cout, S} !== expv) begin
            errors++;
            $display("[TB] FAIL random_%0d: valid %b sum %h required valid 1 sum %h",
                     n, out_valid, {cout, S}, expv);
         end else begin
            pass++;
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
      $display("[TB] random: %0d of 500 results matched", pass);
   endtask

   initial begin
      in_valid = 1'b0;
      A = '0;
      B = '0;
      cin = 1'b0;
      out_ready = 1'b0;
      rst = 1'b1;
      test_reset();
      test_basic();
      test_carry('1, '0, 1'b1, {1'b1, {TOT{1'b0}}}, "full_ripple");
      test_carry(66'h3F_FFFF, 66'd1, 1'b0, 67'h40_0000, "cross_chunk");
      test_carry('1, '1, 1'b1, {1'b1, {TOT{1'b1}}}, "max_operands");
      test_backpressure();
      test_ignore_inputs();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter: width, default 22, chunk width of the internal adder stage (Kogge-Stone chunk).
REQ-002 Parameter: words, default 3, number of chunks per operand; words >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  operand set offered.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 A  input  width*words  operand A.
REQ-008 B  input  width*words  operand B.
REQ-009 cin  input  1  carry into chunk 0.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 S  output  width*words  sum.
REQ-013 cout  output  1  carry out of the top chunk.
REQ-014 busy  output  1  high in BUSY state.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; exactly one active at any time.
REQ-016 in_ready SHALL be 1 only in IDLE; in_ready does not depend combinationally on out_ready.
REQ-017 Input accept = in_valid & in_ready; on accept, A, B and cin are captured into internal registers, chunk index is cleared to 0, and the state goes to BUSY.
REQ-018 In BUSY, each cycle adds chunk[k] of A, chunk[k] of B and the carry register; it writes the width-bit result into S chunk k and updates the carry register with the chunk carry-out.
REQ-019 The carry register is loaded with cin on accept, so chunk 0 uses cin.
REQ-020 Chunk index increments by 1 per BUSY cycle; after chunk words-1, the state goes to DONE and cout takes the final carry.
REQ-021 Latency: out_valid rises exactly words+1 rising edges after the accept edge (4 for the defaults), and no earlier.
REQ-022 In DONE, out_valid = 1, and S and cout are held stable until out_ready = 1.
REQ-023 Output transfer = out_valid & out_ready; on transfer, the state goes to IDLE and out_valid = 0 on the next cycle.
REQ-024 There is no overlap: a new operand set can be accepted no earlier than one cycle after an output transfer.
REQ-025 in_valid, A, B and cin are ignored outside IDLE; changing the inputs during BUSY does not affect the result.
REQ-026 Result: {cout, S} == A + B + cin, evaluated at (width*words+1) bits and sampled at the accept edge, for all operand values.
REQ-027 Carry wrap: an all-ones operand plus cin=1 SHALL ripple the carry through every chunk, giving S = 0 and cout = 1.
REQ-028 S and cout are registered outputs with no combinational path from the inputs.
REQ-029 busy is registered, equals (state == BUSY), and is independent of out_ready.

Reset
REQ-030 rst=1 SHALL force, asynchronously, state=IDLE, in_ready=1, out_valid=0, busy=0, S=0, cout=0, the carry register=0 and the chunk index=0.
REQ-031 Reset in BUSY or DONE SHALL discard the in-flight operation; after rst deasserts, no stale out_valid appears.
REQ-032 While rst=1, in_valid is ignored; the first accept can occur on the first rising edge with rst=0.

Verification
REQ-033 Basic add: A=1, B=2, cin=0, out_ready=1 -> out_valid after 4 edges; S=3, cout=0; then in_ready=1 on the next cycle.
REQ-034 Full ripple: A=all-ones (66 bits), B=0, cin=1 -> S=0, cout=1.
REQ-035 Cross-chunk carry: A=0x3FFFFF (chunk 0 all-ones), B=1, cin=0 -> S=0x400000 and cout=0, which proves the carry passes from chunk 0 into chunk 1.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> S, cout and out_valid stay stable and in_ready=0; when out_ready=1, exactly one transfer occurs.
REQ-037 Reset mid-op: assert rst 2 cycles after accept -> all outputs go to 0 immediately and in_ready=1; no out_valid follows; the next operation (A=5, B=7, cin=1) gives S=13.
REQ-038 Random: 500 sets of random A, B, cin with random out_ready stalls -> every result matches A+B+cin against a (width*words+1)-bit golden model; pass count is reported.
